// File: rtl/pc_redirect_ctrl_pkg.sv
// ============================================================================
// Module : pc_redirect_ctrl_pkg
// Brief  : Shared types and constants for the fetch-PC redirect controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_redirect_ctrl_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_e;

   localparam logic [31:0] RESET_VECTOR_DFLT = 32'h0000_0000;
   localparam logic [31:0] TRAP_VECTOR_DFLT  = 32'h0000_0100;
   localparam int unsigned PC_STEP           = 4;

   function automatic logic word_aligned(input logic [1:0] lsbs);
      return (lsbs == 2'b00);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pc_redirect_ctrl.sv
// ============================================================================
// Module : pc_redirect_ctrl
// Brief  : Fetch-PC owner; applies branch/jump redirects, holding one pending
//          redirect across imem stalls. Optional BRANCH_STATS_EN adds counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_redirect_ctrl
   import pc_redirect_ctrl_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(RESET_VECTOR_DFLT),
   parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = DATA_WIDTH'(TRAP_VECTOR_DFLT)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  imem_ready,
   input  logic                  branch,
   input  logic                  branchN,
   input  logic                  jump,
   input  logic [DATA_WIDTH-1:0] target,
   output logic [DATA_WIDTH-1:0] pc,
   output logic [DATA_WIDTH-1:0] pc_plus4,
   output logic                  fetch_valid,
   output logic                  flush,
   output logic                  misalign
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]           branch_cnt,
   output logic [31:0]           taken_cnt
`endif
);

   state_e                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   pc_q, pc_d;
   logic [DATA_WIDTH-1:0]   pend_tgt_q, pend_tgt_d;
   logic                    take;

   function automatic logic [DATA_WIDTH-1:0] redirect_pc(input logic [DATA_WIDTH-1:0] addr);
      return word_aligned(addr[1:0]) ? addr : TRAP_VECTOR;
   endfunction

   assign pc          = pc_q;
   assign pc_plus4    = pc_q + DATA_WIDTH'(PC_STEP);
   assign fetch_valid = (state_q == RUN);

   always_comb begin
      take       = branchN | jump;
      state_d    = state_q;
      pc_d       = pc_q;
      pend_tgt_d = pend_tgt_q;
      flush      = 1'b0;
      misalign   = 1'b0;
      case (state_q)
         BOOT: begin
            pc_d    = RESET_VECTOR;
            state_d = RUN;
         end
         RUN: begin
            if (take) begin
               flush = 1'b1;
               if (imem_ready) begin
                  pc_d     = redirect_pc(target);
                  misalign = !word_aligned(target[1:0]);
               end else begin
                  pend_tgt_d = target;
                  state_d    = PEND;
               end
            end else if (imem_ready) begin
               pc_d = pc_plus4;
            end
         end
         // Misalign is flagged when the pending target is actually applied,
         // so a stalled misaligned redirect still yields a single pulse.
         PEND: begin
            if (imem_ready) begin
               pc_d     = redirect_pc(pend_tgt_q);
               misalign = !word_aligned(pend_tgt_q[1:0]);
               state_d  = RUN;
            end
         end
         default: state_d = BOOT;
      endcase
      if (rst) begin
         flush    = 1'b0;
         misalign = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= BOOT;
         pc_q       <= RESET_VECTOR;
         pend_tgt_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_tgt_q <= pend_tgt_d;
      end
   end

`ifdef BRANCH_STATS_EN
   if (1) begin : g_branch_stats
      logic [31:0] branch_cnt_q, branch_cnt_d;
      logic [31:0] taken_cnt_q,  taken_cnt_d;

      always_comb begin
         branch_cnt_d = branch_cnt_q;
         taken_cnt_d  = taken_cnt_q;
         if (state_q == RUN) begin
            if (branch)  branch_cnt_d = branch_cnt_q + 32'd1;
            if (branchN) taken_cnt_d  = taken_cnt_q + 32'd1;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
         end else begin
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
         end
      end

      assign branch_cnt = branch_cnt_q;
      assign taken_cnt  = taken_cnt_q;
   end
`else
   logic unused_branch;
   assign unused_branch = branch;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
// ============================================================================
// Module : tb_pc_redirect_ctrl
// Brief  : Self-checking bench for pc_redirect_ctrl (directed + random vs model).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_redirect_ctrl;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam logic [31:0] TV = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst, imem_ready, branch, branchN, jump;
   logic [31:0] target;
   logic [31:0] pc, pc_plus4;
   logic        fetch_valid, flush, misalign;
`ifdef BRANCH_STATS_EN
   logic [31:0] branch_cnt, taken_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: plain booleans for "booting" / "redirect pending"
   bit          m_boot, m_pend;
   logic [31:0] m_pc, m_pend_addr, m_bcnt, m_tcnt;
   logic [31:0] exp_pc, exp_pc4;
   logic        exp_fv, exp_flush, exp_mis;

   always #5 clk = ~clk;

   pc_redirect_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .imem_ready  (imem_ready),
      .branch      (branch),
      .branchN     (branchN),
      .jump        (jump),
      .target      (target),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .fetch_valid (fetch_valid),
      .flush       (flush),
      .misalign    (misalign)
`ifdef BRANCH_STATS_EN
      ,
      .branch_cnt  (branch_cnt),
      .taken_cnt   (taken_cnt)
`endif
   );

   task automatic model_comb();
      bit running;
      bit take;
      running   = !m_boot && !m_pend;
      take      = branchN || jump;
      exp_pc    = m_pc;
      exp_pc4   = m_pc + 32'd4;
      exp_fv    = running;
      exp_flush = !rst && running && take;
      exp_mis   = !rst && imem_ready &&
                  ((running && take && (target % 4 != 0)) || (m_pend && (m_pend_addr % 4 != 0)));
   endtask

   // Advance one clock and move the model by the rules of the redirect policy.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_boot = 1'b1; m_pend = 1'b0; m_pc = RV; m_pend_addr = '0; m_bcnt = '0; m_tcnt = '0;
      end else if (m_boot) begin
         m_boot = 1'b0; m_pc = RV;
      end else if (m_pend) begin
         if (imem_ready) begin
            m_pc   = (m_pend_addr % 4 == 0) ? m_pend_addr : TV;
            m_pend = 1'b0;
         end
      end else begin
         if (branch)  m_bcnt = m_bcnt + 1;
         if (branchN) m_tcnt = m_tcnt + 1;
         if (branchN || jump) begin
            if (imem_ready) m_pc = (target % 4 == 0) ? target : TV;
            else begin m_pend = 1'b1; m_pend_addr = target; end
         end else if (imem_ready) begin
            m_pc = m_pc + 32'd4;
         end
      end
      #1;
   endtask

   task automatic goto(input logic [31:0] addr);
      rst = 0; branch = 0; branchN = 0; jump = 1; target = addr; imem_ready = 1;
      tick();
      jump = 0;
   endtask

   task automatic test_reset();
      rst = 1; imem_ready = 1; branch = 0; branchN = 0; jump = 0; target = '0;
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         n_checks++; if (pc !== RV) begin n_fail++; $display("FAIL rst_pc: got %h want %h", pc, RV); end
         n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fv: got %b want 0", fetch_valid); end
         n_checks++; if (flush !== 1'b0 || misalign !== 1'b0) begin n_fail++; $display("FAIL rst_pulses: got flush=%b misalign=%b want 0/0", flush, misalign); end
      end
`ifdef BRANCH_STATS_EN
      n_checks++; if (branch_cnt !== 0 || taken_cnt !== 0) begin n_fail++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", branch_cnt, taken_cnt); end
`endif
      rst = 0; #1;
      n_checks++; if (pc !== RV || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL boot: got pc=%h fv=%b want %h/0", pc, fetch_valid, RV); end
      tick(); #1;
      n_checks++; if (pc !== RV || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL run0: got pc=%h fv=%b want %h/1", pc, fetch_valid, RV); end
      tick(); #1;
      n_checks++; if (pc !== 32'h4) begin n_fail++; $display("FAIL run1: got %h want 00000004", pc); end
      tick(); #1;
      n_checks++; if (pc !== 32'h8) begin n_fail++; $display("FAIL run2: got %h want 00000008", pc); end
      n_checks++; if (pc_plus4 !== 32'hC) begin n_fail++; $display("FAIL run2_plus4: got %h want 0000000c", pc_plus4); end
   endtask

   task automatic test_taken_branch();
      goto(32'h20);
      branch = 1; branchN = 1; target = 32'h80; #1;
      n_checks++; if (pc !== 32'h20) begin n_fail++; $display("FAIL br_pc_before: got %h want 00000020", pc); end
      n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL br_flush: got %b want 1", flush); end
      tick(); branch = 0; branchN = 0; #1;
      n_checks++; if (pc !== 32'h80) begin n_fail++; $display("FAIL br_pc_target: got %h want 00000080", pc); end
      n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL br_flush_clear: got %b want 0", flush); end
      tick(); #1;
      n_checks++; if (pc !== 32'h84) begin n_fail++; $display("FAIL br_pc_next: got %h want 00000084", pc); end
   endtask

   task automatic test_stall_redirect();
      goto(32'h40);
      imem_ready = 0; jump = 1; target = 32'h200; #1;
      n_checks++; if (flush !== 1'b1 || pc !== 32'h40) begin n_fail++; $display("FAIL stall_take: got flush=%b pc=%h want 1/00000040", flush, pc); end
      tick();
      for (int i = 0; i < 3; i++) begin
         jump = (i == 1); target = (i == 1) ? 32'h300 : 32'h200; imem_ready = 0; #1;
         n_checks++; if (pc !== 32'h40 || fetch_valid !== 1'b0 || flush !== 1'b0) begin
            n_fail++; $display("FAIL pend_hold: got pc=%h fv=%b flush=%b want 00000040/0/0", pc, fetch_valid, flush);
         end
         tick();
      end
      jump = 0; imem_ready = 1; #1;
      n_checks++; if (fetch_valid !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL pend_apply: got fv=%b flush=%b want 0/0", fetch_valid, flush); end
      tick(); #1;
      n_checks++; if (pc !== 32'h200 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL pend_target: got pc=%h fv=%b want 00000200/1", pc, fetch_valid); end
   endtask

   task automatic test_misaligned();
      goto(32'h60);
      branch = 1; branchN = 1; target = 32'h102; #1;
      n_checks++; if (misalign !== 1'b1 || flush !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got misalign=%b flush=%b want 1/1", misalign, flush); end
      tick(); branch = 0; branchN = 0; #1;
      n_checks++; if (pc !== TV) begin n_fail++; $display("FAIL mis_trap: got %h want %h", pc, TV); end
      n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL mis_one_cycle: got %b want 0", misalign); end
   endtask

   task automatic test_wrap();
      goto(32'hFFFF_FFFC); #1;
      n_checks++; if (pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_plus4: got %h want 00000000", pc_plus4); end
      tick(); #1;
      n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want 00000000", pc); end
   endtask

   task automatic test_reset_in_pend();
      goto(32'h400);
      imem_ready = 0; jump = 1; target = 32'h500;
      tick();
      jump = 0; rst = 1; imem_ready = 1; #1;
      n_checks++; if (fetch_valid !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL rstpend_in: got fv=%b flush=%b want 0/0", fetch_valid, flush); end
      tick(); rst = 0; #1;
      n_checks++; if (pc !== RV || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rstpend_boot: got pc=%h fv=%b want %h/0", pc, fetch_valid, RV); end
      tick(); #1;
      n_checks++; if (pc !== RV || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL rstpend_run: got pc=%h fv=%b want %h/1", pc, fetch_valid, RV); end
      tick(); #1;
      n_checks++; if (pc !== RV + 32'd4) begin n_fail++; $display("FAIL rstpend_stale: got %h want %h", pc, RV + 32'd4); end
   endtask

`ifdef BRANCH_STATS_EN
   task automatic test_stats();
      logic [4:0] taken_pat;
      taken_pat = 5'b10101;
      rst = 1; imem_ready = 1; branch = 0; branchN = 0; jump = 0;
      tick();
      rst = 0; branch = 1;
      tick();
      for (int i = 0; i < 5; i++) begin
         branch = 1; branchN = taken_pat[i]; target = 32'h1000 + 32'(i * 16);
         tick();
      end
      branch = 0; branchN = 0; jump = 1; target = 32'h2000;
      tick();
      jump = 0; #1;
      n_checks++; if (branch_cnt !== 32'd5) begin n_fail++; $display("FAIL stats_branch: got %0d want 5", branch_cnt); end
      n_checks++; if (taken_cnt !== 32'd3) begin n_fail++; $display("FAIL stats_taken: got %0d want 3", taken_cnt); end
   endtask
`endif

   task automatic test_random();
      logic [31:0] t;
      for (int i = 0; i < 400; i++) begin
         rst        = ($urandom_range(0, 49) == 0);
         imem_ready = ($urandom_range(0, 3) != 0);
         branch     = ($urandom_range(0, 2) == 0);
         branchN    = branch && ($urandom_range(0, 1) == 1);
         jump       = ($urandom_range(0, 5) == 0);
         t = $urandom;
         if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
         target = t;
         #1;
         model_comb();
         n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc, exp_pc); end
         n_checks++; if (pc_plus4 !== exp_pc4) begin n_fail++; $display("FAIL rnd_plus4[%0d]: got %h want %h", i, pc_plus4, exp_pc4); end
         n_checks++; if (fetch_valid !== exp_fv) begin n_fail++; $display("FAIL rnd_fv[%0d]: got %b want %b", i, fetch_valid, exp_fv); end
         n_checks++; if (flush !== exp_flush) begin n_fail++; $display("FAIL rnd_flush[%0d]: got %b want %b", i, flush, exp_flush); end
         n_checks++; if (misalign !== exp_mis) begin n_fail++; $display("FAIL rnd_misalign[%0d]: got %b want %b", i, misalign, exp_mis); end
`ifdef BRANCH_STATS_EN
         n_checks++; if (branch_cnt !== m_bcnt || taken_cnt !== m_tcnt) begin
            n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, branch_cnt, taken_cnt, m_bcnt, m_tcnt);
         end
`endif
         tick();
      end
      rst = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      m_boot = 1'b1; m_pend = 1'b0; m_pc = RV; m_pend_addr = '0; m_bcnt = '0; m_tcnt = '0;
      test_reset();
      test_taken_branch();
      test_stall_redirect();
      test_misaligned();
      test_wrap();
      test_reset_in_pend();
`ifdef BRANCH_STATS_EN
      test_stats();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Program-counter owner for the fetch stage. It consumes the taken/not-taken decision from the branch comparator, plus jump requests and the target from the EX-stage address adder. It produces the fetch PC, a pipeline flush pulse and a fetch-valid qualifier. Redirects that arrive while instruction memory is stalled are held in a one-entry pending register and applied when fetch resumes.

## Interface
- DATA_WIDTH, 32, PC/target width
- RESET_VECTOR, 32'h0000_0000, PC after reset
- TRAP_VECTOR, 32'h0000_0100, PC on misaligned redirect target
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- imem_ready  in  1  instruction memory accepts fetch this cycle; 0 = fetch stall
- branch  in  1  EX holds a conditional branch (statistics only)
- branchN  in  1  branch taken (comparator output, already gated by branch)
- jump  in  1  EX holds JAL/JALR
- target  in  DATA_WIDTH  redirect address from EX adder
- pc  out  DATA_WIDTH  current fetch address
- pc_plus4  out  DATA_WIDTH  pc + 4, to IF/ID for link value
- fetch_valid  out  1  fetch at pc is real
- flush  out  1  kill IF/ID and ID/EX contents at this edge
- misalign  out  1  one-cycle pulse: redirect target not word aligned
- branch_cnt, taken_cnt  out  32  only with BRANCH_STATS_EN

## Operation
- take = (branchN | jump), evaluated only in RUN.
- Next-PC priority: rst > applied redirect > hold (imem_ready=0) > pc+4.
- Aligned target: target[1:0]==0. Otherwise use TRAP_VECTOR and pulse misalign in the cycle take is seen (RUN) or the pending target is applied (PEND).
- States:
  - BOOT: first cycle after rst. pc=RESET_VECTOR, fetch_valid=0. Goes to RUN unconditionally.
  - RUN, take & imem_ready: pc<=target (or trap). flush=1 this cycle. Stays in RUN.
  - RUN, take & !imem_ready: latch target into pend_tgt. flush=1 this cycle. pc holds. Goes to PEND.
  - RUN, !take: pc<=pc+4 if imem_ready, else hold.
  - PEND: fetch_valid=0, flush=0, take ignored.
    - imem_ready=1: pc<=pend_tgt (or trap). Goes to RUN.
    - imem_ready=0: stays in PEND.
- fetch_valid=1 only in RUN.
- Arithmetic: pc+4 is modulo 2^DATA_WIDTH. 32'hFFFF_FFFC wraps to 0.
- rst in any state, including PEND, discards pend_tgt and returns to BOOT.

## Timing
- Reset values: pc=RESET_VECTOR, state=BOOT, fetch_valid=0, flush=0, misalign=0, counters=0, pend_tgt=0.
- pc, state, pend_tgt and counters are registered.
- flush and misalign are combinational from state and inputs, so pipeline registers clear on the same edge the PC updates.
- Redirect latency: take at cycle N with imem_ready=1 gives pc=target at N+1. The redirect costs two squashed slots (IF, ID).
- Redirect under stall: pc=target on the cycle after the first imem_ready=1 in PEND.
- Simultaneous branchN and jump: same target, treated as a single take.

## Configuration
- BRANCH_STATS_EN defined:
  - branch_cnt increments on each RUN cycle with branch=1.
  - taken_cnt increments on each RUN cycle with branchN=1.
  - Both counters wrap at 2^32 and clear on rst.
- BRANCH_STATS_EN undefined: counter ports and registers are absent.

## Structure
- Shared package: the state enum {BOOT, RUN, PEND}, the RESET_VECTOR/TRAP_VECTOR defaults and the constant PC_STEP=4.
- No sub-module. Optional counters live in a generate block inside this module.

## Test plan
- Reset: hold rst 3 cycles, release. Cycle 1: pc=0, fetch_valid=0. Then pc=0 with fetch_valid=1, then 4, 8.
- Taken branch: pc=0x20, branchN=1, target=0x80, imem_ready=1. flush=1 that cycle, pc=0x80 next cycle, then 0x84.
- Redirect under stall: imem_ready=0, jump=1, target=0x200. flush=1, then PEND for 3 stall cycles with pc held and fetch_valid=0. A second jump to 0x300 during PEND is ignored. On imem_ready=1, pc=0x200 next cycle.
- Misaligned: branchN=1, target=0x102. misalign=1 for one cycle and pc=TRAP_VECTOR next cycle.
- Wrap and reset mid-PEND:
  - pc=0xFFFF_FFFC with no take: next pc=0.
  - rst asserted in PEND: next pc=RESET_VECTOR, state BOOT, stale target never applied.
- Stats (BRANCH_STATS_EN): 5 branches with 3 taken. branch_cnt=5, taken_cnt=3. Jumps are not counted.
